// File: rtl/elevator_pkg.sv
// Shared state/direction encodings and floor-mask helpers for the SCAN elevator controller.
package elevator_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_MOVE_UP   = 2'd1;
  localparam logic [1:0] ST_MOVE_DOWN = 2'd2;
  localparam logic [1:0] ST_DOOR      = 2'd3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MAX_FLOORS = 64;
  typedef logic [MAX_FLOORS-1:0] floor_mask_t;

  // Bits strictly above the given floor.
  function automatic floor_mask_t above_mask(input int floor_idx);
    return ~((floor_mask_t'(2) << floor_idx) - floor_mask_t'(1));
  endfunction

  // Bits strictly below the given floor.
  function automatic floor_mask_t below_mask(input int floor_idx);
    return (floor_mask_t'(1) << floor_idx) - floor_mask_t'(1);
  endfunction

endpackage

// File: rtl/elevator_req_reg.sv
// Pending-call register: latches call pulses, clears the served floor, and reports
// here/above/below relative to the query floor using the registered set.
module elevator_req_reg
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    query_floor,
  input  logic                  clr_en,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  here,
  output logic                  above,
  output logic                  below
);

  logic [NUM_FLOORS-1:0] clr_mask;
  logic [NUM_FLOORS-1:0] above_m;
  logic [NUM_FLOORS-1:0] below_m;

  assign clr_mask = clr_en ? (NUM_FLOORS'(1) << query_floor) : '0;
  assign above_m  = NUM_FLOORS'(above_mask(int'(query_floor)));
  assign below_m  = NUM_FLOORS'(below_mask(int'(query_floor)));

  // Clear beats set so a call at the door floor is absorbed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= (pending | call_req) & ~clr_mask;
    end
  end

  assign here  = pending[query_floor];
  assign above = |(pending & above_m);
  assign below = |(pending & below_m);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN-order N-floor elevator car controller with a shared travel/dwell tick counter.
// Macro ELEVATOR_ESTOP_EN adds an estop input that freezes travel and dwell.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int  NUM_FLOORS  = 4,
  parameter int  FLOOR_TICKS = 30,
  parameter int  DOOR_TICKS  = 10,
  localparam int FLOOR_W     = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1,
  localparam int MAX_TICKS   = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS,
  localparam int CNT_W       = $clog2(MAX_TICKS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_req,
`ifdef ELEVATOR_ESTOP_EN
  input  logic                  estop,
`endif
  output logic [NUM_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  up,
  output logic                  down,
  output logic                  stop,
  output logic                  door_open,
  output logic [CNT_W-1:0]      counter
);

  localparam logic [CNT_W-1:0] FLOOR_LAST = CNT_W'(FLOOR_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST  = CNT_W'(DOOR_TICKS - 1);

  logic [1:0]         state, state_nx;
  logic               dir, dir_nx;
  logic [FLOOR_W-1:0] query_floor;
  logic [CNT_W-1:0]   counter_nx;
  logic               hold, moving, arrive, clr_en;
  logic               here, above, below, ahead, behind;
  logic               up_nx, down_nx;

`ifdef ELEVATOR_ESTOP_EN
  assign hold = estop;
`else
  assign hold = 1'b0;
`endif

  assign moving = (state == ST_MOVE_UP) || (state == ST_MOVE_DOWN);
  assign arrive = moving && !hold && (counter == FLOOR_LAST);

  // On the arrival edge the decision is taken relative to the floor being entered.
  always_comb begin
    query_floor = current_floor;
    if (arrive) begin
      query_floor = (state == ST_MOVE_UP) ? current_floor + FLOOR_W'(1)
                                          : current_floor - FLOOR_W'(1);
    end
  end

  assign ahead  = (dir == DIR_UP) ? above : below;
  assign behind = (dir == DIR_UP) ? below : above;

  elevator_req_reg #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_req_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .call_req    (call_req),
    .query_floor (query_floor),
    .clr_en      (clr_en),
    .pending     (pending),
    .here        (here),
    .above       (above),
    .below       (below)
  );

  always_comb begin
    state_nx   = state;
    dir_nx     = dir;
    counter_nx = counter;
    case (state)
      ST_IDLE: begin
        counter_nx = '0;
        if (here) begin
          state_nx = ST_DOOR;
        end else if (!hold && ahead) begin
          state_nx = (dir == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
        end else if (!hold && behind) begin
          state_nx = (dir == DIR_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
          dir_nx   = (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (arrive) begin
          counter_nx = '0;
          if (here) begin
            state_nx = ST_DOOR;
          end else if (!ahead) begin
            state_nx = ST_IDLE;
          end
        end else if (!hold) begin
          counter_nx = counter + 1'b1;
        end
      end
      default: begin
        if (!hold) begin
          if (counter == DOOR_LAST) begin
            counter_nx = '0;
            state_nx   = ST_IDLE;
            if (ahead) begin
              state_nx = (dir == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
            end else if (behind) begin
              state_nx = (dir == DIR_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
              dir_nx   = (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
            end
          end else begin
            counter_nx = counter + 1'b1;
          end
        end
      end
    endcase
  end

  assign clr_en  = (state == ST_DOOR) || (state_nx == ST_DOOR);
  assign up_nx   = (state_nx == ST_MOVE_UP) && !hold;
  assign down_nx = (state_nx == ST_MOVE_DOWN) && !hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      dir           <= DIR_UP;
      current_floor <= '0;
      counter       <= '0;
      up            <= 1'b0;
      down          <= 1'b0;
      stop          <= 1'b1;
      door_open     <= 1'b0;
    end else begin
      state         <= state_nx;
      dir           <= dir_nx;
      current_floor <= query_floor;
      counter       <= counter_nx;
      up            <= up_nx;
      down          <= down_nx;
      stop          <= !(up_nx || down_nx);
      door_open     <= (state_nx == ST_DOOR);
    end
  end

endmodule
